// File: rtl/regs_pkg.sv
// Shared constants and debug-FSM state type for the register file.
package regs_pkg;
  localparam int          REG_ADDR_W = 5;
  localparam int          REG_DATA_W = 32;
  localparam logic [4:0]  ZERO_REG   = 5'd0;
  localparam int          NUM_RPORTS = 3;

  typedef enum logic {
    DBG_IDLE = 1'b0,
    DBG_ACK  = 1'b1
  } dbg_state_e;
endpackage

// File: rtl/regs_rport.sv
// One read port: x0 forced to zero, then same-cycle write-back bypass, then storage.
module regs_rport
  import regs_pkg::*;
#(
  parameter int AW   = REG_ADDR_W,
  parameter int XLEN = REG_DATA_W
) (
  input  logic [AW-1:0]   raddr_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            wb_commit_i,
  input  logic [XLEN-1:0] mem_word_i,
  output logic [XLEN-1:0] rdata_o
);
  always_comb begin
    rdata_o = mem_word_i;
    if (raddr_i == ZERO_REG)
      rdata_o = '0;
    else if (wb_commit_i && (raddr_i == wb_addr_i))
      rdata_o = wb_data_i;
  end
endmodule

// File: rtl/regs.sv
// RV32I general-purpose register file: bypassed operand reads, handshaked
// debug write port that yields to write-back, and a committed-write counter.
module regs
  import regs_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int XLEN    = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_W-1:0]     wb_addr_i,
  input  logic [XLEN-1:0]           wb_data_i,
  input  logic                      wb_wen_i,
  input  logic [REG_ADDR_W-1:0]     rs1_raddr_i,
  input  logic [REG_ADDR_W-1:0]     rs2_raddr_i,
  output logic [XLEN-1:0]           rs1_rdata_o,
  output logic [XLEN-1:0]           rs2_rdata_o,
  input  logic [REG_ADDR_W-1:0]     dbg_addr_i,
  input  logic [XLEN-1:0]           dbg_wdata_i,
  input  logic                      dbg_we_i,
  output logic                      dbg_ack_o,
  output logic [XLEN-1:0]           dbg_rdata_o,
  output logic [31:0]               wr_cnt_o
);
  logic [XLEN-1:0] mem_q [REG_NUM];
  logic [XLEN-1:0] mem_d [REG_NUM];
  dbg_state_e      state_q, state_d;
  logic [31:0]     wr_cnt_q, wr_cnt_d;
  logic            wb_commit, dbg_wr;

  logic [NUM_RPORTS-1:0][REG_ADDR_W-1:0] rd_addr;
  logic [NUM_RPORTS-1:0][XLEN-1:0]       rd_data;

  assign wb_commit = wb_wen_i && (wb_addr_i != ZERO_REG);
  // Any write-back activity, even to x0, holds off the debug write.
  assign dbg_wr    = (state_q == DBG_IDLE) && dbg_we_i && !wb_wen_i;

  always_comb begin
    state_d = DBG_IDLE;
    if (state_q == DBG_IDLE && dbg_wr)
      state_d = DBG_ACK;
  end

  always_comb begin
    for (int i = 0; i < REG_NUM; i++) mem_d[i] = mem_q[i];
    if (wb_commit)
      mem_d[wb_addr_i] = wb_data_i;
    else if (dbg_wr && dbg_addr_i != ZERO_REG)
      mem_d[dbg_addr_i] = dbg_wdata_i;
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wb_commit) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) mem_q[i] <= '0;
      state_q  <= DBG_IDLE;
      wr_cnt_q <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) mem_q[i] <= mem_d[i];
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_addr = {dbg_addr_i, rs2_raddr_i, rs1_raddr_i};

  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rport
    regs_rport #(.AW(REG_ADDR_W), .XLEN(XLEN)) u_rport (
      .raddr_i     (rd_addr[k]),
      .wb_addr_i   (wb_addr_i),
      .wb_data_i   (wb_data_i),
      .wb_commit_i (wb_commit),
      .mem_word_i  (mem_q[rd_addr[k]]),
      .rdata_o     (rd_data[k])
    );
  end

  assign rs1_rdata_o = rd_data[0];
  assign rs2_rdata_o = rd_data[1];
  assign dbg_rdata_o = rd_data[2];
  assign dbg_ack_o   = (state_q == DBG_ACK);
  assign wr_cnt_o    = wr_cnt_q;
endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs against an array/counter reference model.
module tb_regs;
  logic        clk = 0, rst = 0;
  logic [4:0]  wb_addr_i = 0, rs1_raddr_i = 0, rs2_raddr_i = 0, dbg_addr_i = 0;
  logic [31:0] wb_data_i = 0, dbg_wdata_i = 0;
  logic        wb_wen_i = 0, dbg_we_i = 0;
  logic [31:0] rs1_rdata_o, rs2_rdata_o, dbg_rdata_o, wr_cnt_o;
  logic        dbg_ack_o;

  int total = 0, bad = 0;
  logic [31:0] ref_mem [32];
  logic [31:0] ref_cnt;

  always #5 clk = ~clk;

  regs dut (
    .clk(clk), .rst(rst),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_wen_i(wb_wen_i),
    .rs1_raddr_i(rs1_raddr_i), .rs2_raddr_i(rs2_raddr_i),
    .rs1_rdata_o(rs1_rdata_o), .rs2_rdata_o(rs2_rdata_o),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_we_i(dbg_we_i),
    .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o), .wr_cnt_o(wr_cnt_o)
  );

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_wen_i && wb_addr_i != 0 && wb_addr_i == a) return wb_data_i;
    return ref_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    ref_cnt = 32'd0;
  endtask

  // Advance one edge, apply write-back to the model, land 1ns after the edge.
  task automatic step();
    @(posedge clk);
    if (wb_wen_i && wb_addr_i != 0) begin
      ref_mem[wb_addr_i] = wb_data_i;
      ref_cnt = ref_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; #1; model_reset();
    total++;
    if (wr_cnt_o !== 32'd0 || dbg_ack_o !== 1'b0) begin
      bad++; $display("FAIL reset_init cnt=%h ack=%b want 0/0", wr_cnt_o, dbg_ack_o);
    end
    @(posedge clk); #1; rst = 0;
    wb_wen_i = 1; wb_addr_i = 5; wb_data_i = 32'h1234; step();
    wb_wen_i = 0; rs1_raddr_i = 5; #1;
    total++;
    if (rs1_rdata_o !== 32'h1234) begin
      bad++; $display("FAIL reset_prewrite x5=%h want 00001234", rs1_rdata_o);
    end
    rst = 1; #1; model_reset();
    total++;
    if (rs1_rdata_o !== 32'd0 || wr_cnt_o !== 32'd0) begin
      bad++; $display("FAIL reset_clear x5=%h cnt=%h want 0/0", rs1_rdata_o, wr_cnt_o);
    end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_x0();
    logic [31:0] c0;
    c0 = ref_cnt;
    wb_wen_i = 1; wb_addr_i = 0; wb_data_i = 32'hDEAD_BEEF;
    rs1_raddr_i = 0; rs2_raddr_i = 0; #1;
    total++;
    if (rs1_rdata_o !== 32'd0 || rs2_rdata_o !== 32'd0) begin
      bad++; $display("FAIL x0_same rs1=%h rs2=%h want 0", rs1_rdata_o, rs2_rdata_o);
    end
    step(); wb_wen_i = 0; #1;
    total++;
    if (rs1_rdata_o !== 32'd0 || wr_cnt_o !== c0) begin
      bad++; $display("FAIL x0_after rs1=%h cnt=%h want 0/%h", rs1_rdata_o, wr_cnt_o, c0);
    end
  endtask

  task automatic test_bypass();
    wb_wen_i = 1; wb_addr_i = 3; wb_data_i = 32'hA5A5_0001;
    rs1_raddr_i = 3; rs2_raddr_i = 3; #1;
    total++;
    if (rs1_rdata_o !== 32'hA5A5_0001 || rs2_rdata_o !== 32'hA5A5_0001) begin
      bad++; $display("FAIL bypass_same rs1=%h rs2=%h want a5a50001", rs1_rdata_o, rs2_rdata_o);
    end
    step(); wb_wen_i = 0; wb_data_i = 32'h0; #1;
    total++;
    if (rs1_rdata_o !== 32'hA5A5_0001 || rs2_rdata_o !== 32'hA5A5_0001) begin
      bad++; $display("FAIL bypass_stored rs1=%h rs2=%h want a5a50001", rs1_rdata_o, rs2_rdata_o);
    end
  endtask

  task automatic test_dbg_contention();
    logic [31:0] v8;
    v8 = $urandom | 32'h1;
    dbg_we_i = 1; dbg_addr_i = 7; dbg_wdata_i = 32'h55;
    wb_wen_i = 1; wb_addr_i = 8; wb_data_i = v8;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (dbg_ack_o !== 1'b0) begin
        bad++; $display("FAIL dbg_blocked cyc=%0d ack=%b want 0", i, dbg_ack_o);
      end
    end
    wb_wen_i = 0;
    step(); ref_mem[7] = 32'h55;
    total++;
    if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h55) begin
      bad++; $display("FAIL dbg_ack ack=%b x7=%h want 1/00000055", dbg_ack_o, dbg_rdata_o);
    end
    dbg_we_i = 0;
    step(); rs1_raddr_i = 8; #1;
    total++;
    if (dbg_ack_o !== 1'b0 || rs1_rdata_o !== v8 || wr_cnt_o !== ref_cnt) begin
      bad++; $display("FAIL dbg_after ack=%b x8=%h cnt=%h want 0/%h/%h",
                      dbg_ack_o, rs1_rdata_o, wr_cnt_o, v8, ref_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wb_wen_i  = $urandom_range(0, 1);
      wb_addr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wb_data_i = $urandom;
      rs1_raddr_i = $urandom_range(0, 1) ? wb_addr_i : 5'($urandom);
      rs2_raddr_i = 5'($urandom);
      dbg_addr_i  = $urandom_range(0, 1) ? wb_addr_i : 5'($urandom);
      #1;
      total++;
      if (rs1_rdata_o !== ref_read(rs1_raddr_i) || rs2_rdata_o !== ref_read(rs2_raddr_i) ||
          dbg_rdata_o !== ref_read(dbg_addr_i) || wr_cnt_o !== ref_cnt) begin
        bad++;
        $display("FAIL random n=%0d rs1=%h/%h rs2=%h/%h dbg=%h/%h cnt=%h/%h", n,
                 rs1_rdata_o, ref_read(rs1_raddr_i), rs2_rdata_o, ref_read(rs2_raddr_i),
                 dbg_rdata_o, ref_read(dbg_addr_i), wr_cnt_o, ref_cnt);
      end
      step();
    end
    wb_wen_i = 0;
  endtask

  task automatic test_cnt_wrap();
    force dut.wr_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.wr_cnt_q;
    ref_cnt = 32'hFFFF_FFFE;
    wb_wen_i = 1; wb_addr_i = 9; wb_data_i = $urandom;
    step();
    total++;
    if (wr_cnt_o !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL cnt_max cnt=%h want ffffffff", wr_cnt_o);
    end
    wb_addr_i = 10; step(); wb_wen_i = 0;
    total++;
    if (wr_cnt_o !== 32'd0 || ref_cnt !== 32'd0) begin
      bad++; $display("FAIL cnt_wrap cnt=%h want 00000000", wr_cnt_o);
    end
  endtask

  task automatic test_rst_mid_handshake();
    wb_wen_i = 0;
    dbg_we_i = 1; dbg_addr_i = 12; dbg_wdata_i = 32'hCAFE_F00D;
    rst = 1; #1; model_reset();
    @(posedge clk); #1;
    total++;
    if (dbg_ack_o !== 1'b0) begin
      bad++; $display("FAIL rst_hs_ack ack=%b want 0", dbg_ack_o);
    end
    dbg_we_i = 0; rst = 0;
    step(); rs1_raddr_i = 12; #1;
    total++;
    if (dbg_ack_o !== 1'b0 || rs1_rdata_o !== 32'd0 || dbg_rdata_o !== 32'd0) begin
      bad++; $display("FAIL rst_hs_reg ack=%b x12=%h dbg=%h want 0/0/0",
                      dbg_ack_o, rs1_rdata_o, dbg_rdata_o);
    end
  endtask

  task automatic test_dbg_x0();
    dbg_we_i = 1; dbg_addr_i = 0; dbg_wdata_i = 32'h1111_2222;
    step(); dbg_we_i = 0;
    total++;
    if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'd0) begin
      bad++; $display("FAIL dbg_x0 ack=%b x0=%h want 1/0", dbg_ack_o, dbg_rdata_o);
    end
    step();
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_x0();
    test_bypass();
    test_dbg_contention();
    test_dbg_x0();
    test_random();
    test_cnt_wrap();
    test_rst_mid_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
